// File: rtl/m72_raster_irq_gen.sv
// -----------------------------------------------------------------------------
// m72_raster_irq_gen
//
// Raster timing generator and interrupt requester for the M72 video/CPU
// subsystem. Produces the h/v counters, registered sync/blank decodes, and
// the vblank and raster-line interrupt requests with vector presentation.
// The CPU-domain acknowledge arrives as a level toggle and is brought into
// pixel_clock through a two-flop synchronizer plus an edge-detect flop.
//
// Build option:
//   M72_HINT_EN  defined   -> raster-line interrupt implemented
//                undefined -> hint_pending tied 0, raster_en/raster_line
//                             ignored, irq_vector constant VEC_VBL,
//                             irq_req = vbl_pending
//
// Ports:
//   pixel_clock     in   1  pixel clock
//   reset_n         in   1  asynchronous active-low reset
//   raster_en       in   1  enable raster-line interrupt (quasi-static)
//   raster_line     in   9  line number for raster interrupt (quasi-static)
//   irq_ack_toggle  in   1  CPU-domain acknowledge, one ack per level change
//   h_count         out  9  current pixel counter
//   v_count         out  9  current line counter
//   hs, vs, hb, vb  out  1  active-high sync / blank (1-cycle lag vs counters)
//   irq_req         out  1  OR of the pending flags
//   irq_vector      out  8  vector of the highest-priority pending source
//   vbl_pending     out  1  vblank interrupt pending
//   hint_pending    out  1  raster-line interrupt pending
// -----------------------------------------------------------------------------
module m72_raster_irq_gen #(
    parameter int unsigned H_TOTAL  = 512,
    parameter int unsigned V_TOTAL  = 284,
    parameter int unsigned H_ACTIVE = 384,
    parameter int unsigned V_ACTIVE = 256,
    parameter int unsigned HS_START = 416,
    parameter int unsigned HS_END   = 447,
    parameter int unsigned VS_START = 268,
    parameter int unsigned VS_END   = 270,
    parameter logic [7:0]  VEC_VBL  = 8'h20,
    parameter logic [7:0]  VEC_HINT = 8'h22
) (
    input  logic       pixel_clock,
    input  logic       reset_n,
    input  logic       raster_en,
    input  logic [8:0] raster_line,
    input  logic       irq_ack_toggle,
    output logic [8:0] h_count,
    output logic [8:0] v_count,
    output logic       hs,
    output logic       vs,
    output logic       hb,
    output logic       vb,
    output logic       irq_req,
    output logic [7:0] irq_vector,
    output logic       vbl_pending,
    output logic       hint_pending
);

    // Counter-width copies of the timing constants keep every compare 9 bits.
    localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT       = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT       = 9'(V_ACTIVE);
    localparam logic [8:0] V_ACT_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [8:0] HS_FIRST    = 9'(HS_START);
    localparam logic [8:0] HS_LAST     = 9'(HS_END);
    localparam logic [8:0] VS_FIRST    = 9'(VS_START);
    localparam logic [8:0] VS_LAST     = 9'(VS_END);

    // ------------------------------------------------------------------------
    // Raster counters and registered decodes
    // ------------------------------------------------------------------------
    logic [8:0] h_d, h_q;
    logic [8:0] v_d, v_q;
    logic       hs_d, hs_q, vs_d, vs_q, hb_d, hb_q, vb_d, vb_q;

    // NOTE: every always_comb output gets a default on its first line so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        h_d = h_q + 9'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
        end
    end

    // Decodes look at the counters as they are now, so they land one cycle
    // after the counter value that caused them.
    always_comb begin
        hb_d = (h_q >= H_ACT);
        vb_d = (v_q >= V_ACT);
        hs_d = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        vs_d = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    end

    // ------------------------------------------------------------------------
    // Acknowledge synchronizer: s1/s2 resolve metastability, s3 remembers the
    // previous synchronized level so any level change becomes a 1-cycle pulse.
    // A toggle stable before edge N is in s1 at N, s2 at N+1, so the pulse is
    // high in the cycle that ends with edge N+2, where the flag clears.
    // ------------------------------------------------------------------------
    logic ack_s1_q, ack_s2_q, ack_s3_q;
    logic ack_pulse;

    assign ack_pulse = ack_s2_q ^ ack_s3_q;

    // ------------------------------------------------------------------------
    // Interrupt flags
    // ------------------------------------------------------------------------
    logic vbl_event;
    logic vbl_d, vbl_q;

    // Last pixel of the last active line: the edge that moves v into vblank.
    assign vbl_event = (h_q == H_LAST) && (v_q == V_ACT_LAST);

`ifdef M72_HINT_EN
    logic       hint_event;
    logic       ack_vbl, ack_hint;
    logic       hint_d, hint_q;
    logic       irq_req_d, irq_req_q;
    logic [7:0] irq_vector_d, irq_vector_q;

    // h is only at H_ACTIVE-1 once per line, so at most one event per line;
    // a raster_line beyond the last line can never equal v_q.
    assign hint_event = raster_en && (v_q == raster_line) && (h_q == H_ACT - 9'd1);

    always_comb begin
        // The ack goes to whatever irq_vector currently shows: vblank first.
        ack_vbl      = ack_pulse && vbl_q;
        ack_hint     = ack_pulse && !vbl_q && hint_q;
        // Set is OR-ed in last so a coincident set beats the clear.
        vbl_d        = (vbl_q  && !ack_vbl)  || vbl_event;
        hint_d       = (hint_q && !ack_hint) || hint_event;
        irq_req_d    = vbl_d || hint_d;
        irq_vector_d = (!vbl_d && hint_d) ? VEC_HINT : VEC_VBL;
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            hint_q       <= 1'b0;
            irq_req_q    <= 1'b0;
            irq_vector_q <= VEC_VBL;
        end else begin
            hint_q       <= hint_d;
            irq_req_q    <= irq_req_d;
            irq_vector_q <= irq_vector_d;
        end
    end

    assign hint_pending = hint_q;
    assign irq_req      = irq_req_q;
    assign irq_vector   = irq_vector_q;
`else
    always_comb begin
        vbl_d = (vbl_q && !ack_pulse) || vbl_event;
    end

    assign hint_pending = 1'b0;
    assign irq_req      = vbl_q;
    assign irq_vector   = VEC_VBL;

    // Raster-line inputs have no function in this build.
    logic unused_hint_inputs;
    assign unused_hint_inputs = ^{raster_en, raster_line};
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q      <= '0;
            v_q      <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hb_q     <= 1'b0;
            vb_q     <= 1'b0;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            ack_s3_q <= 1'b0;
            vbl_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hb_q     <= hb_d;
            vb_q     <= vb_d;
            ack_s1_q <= irq_ack_toggle;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
            vbl_q    <= vbl_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign hb          = hb_q;
    assign vb          = vb_q;
    assign vbl_pending = vbl_q;

endmodule

// File: tb/tb_m72_raster_irq_gen.sv
// -----------------------------------------------------------------------------
// tb_m72_raster_irq_gen
//
// Directed bench for m72_raster_irq_gen. The frame is shortened vertically
// (20 lines, 12 active) so several frames fit in a short run; the horizontal
// timing keeps its full 512-pixel values. A frame-position model derives the
// expected outputs from the absolute edge count since reset, and a compare
// process checks every output on every falling edge. Hand-computed literal
// checks pin the model at key positions.
// -----------------------------------------------------------------------------
module tb_m72_raster_irq_gen;

    localparam int H_TOTAL  = 512;
    localparam int V_TOTAL  = 20;
    localparam int H_ACTIVE = 384;
    localparam int V_ACTIVE = 12;
    localparam int HS_START = 416;
    localparam int HS_END   = 447;
    localparam int VS_START = 14;
    localparam int VS_END   = 16;
    localparam int FRAME    = H_TOTAL * V_TOTAL;   // 10240 edges per frame

    logic       pixel_clock;
    logic       reset_n;
    logic       raster_en;
    logic [8:0] raster_line;
    logic       irq_ack_toggle;
    logic [8:0] h_count, v_count;
    logic       hs, vs, hb, vb;
    logic       irq_req;
    logic [7:0] irq_vector;
    logic       vbl_pending, hint_pending;

    m72_raster_irq_gen #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .HS_START(HS_START),
        .HS_END  (HS_END),
        .VS_START(VS_START),
        .VS_END  (VS_END),
        .VEC_VBL (8'h20),
        .VEC_HINT(8'h22)
    ) dut (
        .pixel_clock   (pixel_clock),
        .reset_n       (reset_n),
        .raster_en     (raster_en),
        .raster_line   (raster_line),
        .irq_ack_toggle(irq_ack_toggle),
        .h_count       (h_count),
        .v_count       (v_count),
        .hs            (hs),
        .vs            (vs),
        .hb            (hb),
        .vb            (vb),
        .irq_req       (irq_req),
        .irq_vector    (irq_vector),
        .vbl_pending   (vbl_pending),
        .hint_pending  (hint_pending)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

`ifdef M72_HINT_EN
    localparam bit HINT_BUILD = 1'b1;
`else
    localparam bit HINT_BUILD = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------------
    // Model: position is a pure function of edges since reset release.
    // ------------------------------------------------------------------------
    int m_e    = 0;      // posedges since reset release
    bit m_vbl  = 1'b0;
    bit m_hint = 1'b0;
    bit m_seen = 1'b0;   // last toggle level the model has accounted for
    int ack_q[$];        // edge numbers at which an ack takes effect

    function automatic int hc(input int n);
        return n % H_TOTAL;
    endfunction

    function automatic int vc(input int n);
        return (n / H_TOTAL) % V_TOTAL;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, m_e);
            if (errors >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge pixel_clock or negedge reset_n);
            if (!reset_n) begin
                m_e    = 0;
                m_vbl  = 1'b0;
                m_hint = 1'b0;
                m_seen = 1'b0;
                ack_q.delete();
            end else begin
                int  p;
                bit  vbl_ev;
                bit  hint_ev;
                p       = m_e;          // counter value before this edge
                m_e     = m_e + 1;
                vbl_ev  = (hc(p) == H_TOTAL - 1) && (vc(p) == V_ACTIVE - 1);
                hint_ev = HINT_BUILD && raster_en && (hc(p) == H_ACTIVE - 1)
                          && (int'(raster_line) == vc(p));
                if (irq_ack_toggle != m_seen) begin
                    ack_q.push_back(m_e + 2);
                    m_seen = irq_ack_toggle;
                end
                if (ack_q.size() > 0 && ack_q[0] == m_e) begin
                    void'(ack_q.pop_front());
                    if (m_vbl) m_vbl = 1'b0;
                    else       m_hint = 1'b0;
                end
                if (vbl_ev)  m_vbl  = 1'b1;
                if (hint_ev) m_hint = 1'b1;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    initial begin
        forever begin
            @(negedge pixel_clock);
            if (reset_n) begin
                int         d;
                logic [7:0] e_vec;
                logic [32:0] exp_v, act_v;
                d     = (m_e == 0) ? 0 : m_e - 1;
                e_vec = (!m_vbl && m_hint) ? 8'h22 : 8'h20;
                exp_v = {9'(hc(m_e)), 9'(vc(m_e)),
                         (hc(d) >= HS_START) && (hc(d) <= HS_END),
                         (vc(d) >= VS_START) && (vc(d) <= VS_END),
                         hc(d) >= H_ACTIVE,
                         vc(d) >= V_ACTIVE,
                         m_vbl || m_hint, e_vec, m_vbl, m_hint};
                act_v = {h_count, v_count, hs, vs, hb, vb,
                         irq_req, irq_vector, vbl_pending, hint_pending};
                check("cycle{h,v,hs,vs,hb,vb,req,vec,vbl,hint}", act_v, exp_v);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic run_to(input int target);
        int budget;
        budget = target - m_e + 8;
        while (m_e < target && budget > 0) begin
            @(negedge pixel_clock);
            budget--;
        end
        if (m_e != target) check("run_to_timeout", 64'(m_e), 64'(target));
    endtask

    task automatic toggle_at(input int e);
        run_to(e);
        irq_ack_toggle = ~irq_ack_toggle;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h"},    h_count,      9'd0);
        check({tag, "_v"},    v_count,      9'd0);
        check({tag, "_sync"}, {hs, vs, hb, vb}, 4'b0000);
        check({tag, "_req"},  irq_req,      1'b0);
        check({tag, "_vec"},  irq_vector,   8'h20);
        check({tag, "_flags"}, {vbl_pending, hint_pending}, 2'b00);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        reset_n        = 1'b0;
        raster_en      = 1'b0;
        raster_line    = 9'd0;
        irq_ack_toggle = 1'b0;
        repeat (3) @(negedge pixel_clock);
        #1 check_all_zero("reset");
        #1 reset_n = 1'b1;
        raster_en   = 1'b1;
        raster_line = 9'd5;

        // Counting from 0 after release.
        run_to(1);  check("h_e1", h_count, 9'd1);
        run_to(2);  check("h_e2", h_count, 9'd2);
        run_to(3);  check("h_e3", h_count, 9'd3);

        // Ack with nothing pending must be dropped, not held for later.
        toggle_at(100);

        // hb / hs decodes on line 0, lagging the counter by one cycle.
        run_to(384); check("hb_before", hb, 1'b0);
        run_to(385); check("hb_rise",   hb, 1'b1);
        run_to(416); check("hs_before", hs, 1'b0);
        run_to(417); check("hs_rise",   hs, 1'b1);
        run_to(448); check("hs_last",   hs, 1'b1);
        run_to(449); check("hs_fall",   hs, 1'b0);

        // h wrap and v step on the same edge.
        run_to(511); check("hv_pre_wrap", {v_count, h_count}, {9'd0, 9'd511});
        run_to(512); check("hv_wrap",     {v_count, h_count}, {9'd1, 9'd0});

        // Raster interrupt on line 5: edge after v=5,h=383 is 5*512+384.
        run_to(2944);
        check("hint_set",  hint_pending, HINT_BUILD);
        check("hint_req",  irq_req,      HINT_BUILD);
        check("hint_vec",  irq_vector,   HINT_BUILD ? 8'h22 : 8'h20);
        toggle_at(3000);
        run_to(3002); check("hint_before_ack", hint_pending, HINT_BUILD);
        run_to(3003); check("hint_acked", {irq_req, hint_pending}, 2'b00);

        // Vblank: edge after v=11,h=511 is 12*512 = 6144.
        run_to(6143); check("vbl_before", {vbl_pending, v_count, h_count}, {1'b0, 9'd11, 9'd511});
        run_to(6144);
        check("vbl_set",  {vbl_pending, irq_req, vb}, 3'b110);
        check("vbl_vec",  irq_vector, 8'h20);
        run_to(6145); check("vb_rise", vb, 1'b1);
        toggle_at(6200);
        run_to(6202); check("vbl_hold", vbl_pending, 1'b1);
        run_to(6203); check("vbl_acked", {vbl_pending, irq_req}, 2'b00);

        // Move the raster line onto the last active line for the collision.
        run_to(7000); raster_line = 9'd11;

        // vs covers lines 14..16 with one cycle of lag.
        run_to(7168); check("vs_before", vs, 1'b0);
        run_to(7169); check("vs_rise",   vs, 1'b1);
        run_to(8704); check("vs_last",   vs, 1'b1);
        run_to(8705); check("vs_fall",   vs, 1'b0);

        // Frame 1: hint at 10240+11*512+384, vblank at 10240+6144.
        run_to(FRAME + 5632 + 384);
        check("coll_hint_first", {vbl_pending, hint_pending}, {1'b0, HINT_BUILD});
        run_to(FRAME + 6144);
        check("coll_both", {vbl_pending, hint_pending}, {1'b1, HINT_BUILD});
        check("coll_vec",  irq_vector, 8'h20);
        toggle_at(FRAME + 6160);
        run_to(FRAME + 6163);
        check("coll_ack1_flags", {vbl_pending, hint_pending}, {1'b0, HINT_BUILD});
        check("coll_ack1_vec",   irq_vector, HINT_BUILD ? 8'h22 : 8'h20);
        check("coll_ack1_req",   irq_req,    HINT_BUILD);
        toggle_at(FRAME + 6170);
        run_to(FRAME + 6173);
        check("coll_ack2", {irq_req, vbl_pending, hint_pending}, 3'b000);

        // Out-of-range raster line for the next two frames.
        run_to(FRAME + 6300); raster_line = 9'd300;

        // v wrap 19 -> 0.
        run_to(2 * FRAME - 1); check("v_pre_wrap", {v_count, h_count}, {9'd19, 9'd511});
        run_to(2 * FRAME);     check("v_wrap",     {v_count, h_count}, {9'd0, 9'd0});

        // Frame 2 vblank stays pending; frame 3 ack lands on the set edge.
        run_to(2 * FRAME + 6144); check("vbl_f2", vbl_pending, 1'b1);
        toggle_at(3 * FRAME + 6141);
        run_to(3 * FRAME + 6143); check("set_vs_clr_pre",  vbl_pending, 1'b1);
        run_to(3 * FRAME + 6144);
        check("set_vs_clr",     vbl_pending,  1'b1);
        check("line300_nohint", hint_pending, 1'b0);
        run_to(3 * FRAME + 6145); check("set_vs_clr_post", vbl_pending, 1'b1);

        // Frame 4: hint on line 5, then disable raster_en; flag must remain.
        run_to(4 * FRAME - 240); raster_line = 9'd5;
        run_to(4 * FRAME + 2944); check("f4_hint", hint_pending, HINT_BUILD);
        run_to(4 * FRAME + 3040); raster_en = 1'b0;
        run_to(4 * FRAME + 3540); check("en_off_keeps", hint_pending, HINT_BUILD);

        // Reset mid-line at v=8, h=200 with a toggle still in flight.
        toggle_at(4 * FRAME + 8 * 512 + 199);
        run_to(4 * FRAME + 8 * 512 + 200);
        check("pre_rst_pos",   {v_count, h_count}, {9'd8, 9'd200});
        check("pre_rst_flags", {vbl_pending, hint_pending}, {1'b1, HINT_BUILD});
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (3) @(negedge pixel_clock);
        #2 reset_n = 1'b1;
        #1 check_all_zero("post_rst");
        run_to(1); check("rst_h_e1", h_count, 9'd1);
        run_to(6); check("rst_inflight_ack", {irq_req, vbl_pending}, 2'b00);
        run_to(600); check("rst_v1", v_count, 9'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
